// File: rtl/signal_generator_v1_0.sv
// AXI-Stream slave that replays {level, duration} words as a pulse train on a single output pin.
// Control mirrors the signal detector: enabled arms, trigger starts, stopped flags completion.
`timescale 1ns/1ps
module signal_generator_v1_0 #(
   parameter int   C_S00_AXIS_TDATA_WIDTH = 32,
   parameter logic IDLE_LEVEL             = 1'b0
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_areset,
   input  logic                                  enabled,
   input  logic                                  trigger_input,
   input  logic [15:0]                           number_words,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tkeep,
   input  logic                                  s00_axis_tlast,
   input  logic                                  s00_axis_tvalid,
   output logic                                  s00_axis_tready,
   output logic                                  signal_output,
   output logic                                  signal_state,
   output logic                                  stopped,
   output logic                                  underrun,
   output logic                                  fifo_reset,
   output logic [15:0]                           words_played
);

   localparam int DW = C_S00_AXIS_TDATA_WIDTH - 1;
   localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOAD, S_PLAY, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] cnt;
   logic          final_word;

   logic          hs, null_word, load_hs, last_hs, seg_end, final_in;
   logic [DW-1:0] dur_eff;
   logic [15:0]   wp_inc;

   assign hs        = s00_axis_tvalid & s00_axis_tready;
   assign null_word = (s00_axis_tkeep == '0);
   assign load_hs   = hs & ~null_word;
   // a null word carrying tlast still closes the run
   assign last_hs   = hs & null_word & s00_axis_tlast;
   assign seg_end   = (state == S_PLAY) && (cnt == CNT_ONE);
   assign dur_eff   = (s00_axis_tdata[DW-1:0] == '0) ? CNT_ONE : s00_axis_tdata[DW-1:0];
   assign wp_inc    = (words_played == 16'hFFFF) ? 16'hFFFF : words_played + 16'd1;
   assign final_in  = s00_axis_tlast | ((number_words != 16'd0) && (wp_inc == number_words));

   // state register
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) state <= S_IDLE;
      else                 state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      if (!enabled) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_ARMED;
            S_ARMED: if (trigger_input) state_nxt = S_LOAD;
            S_LOAD: begin
               if (load_hs)      state_nxt = S_PLAY;
               else if (last_hs) state_nxt = S_DONE;
            end
            S_PLAY: begin
               if (seg_end) begin
                  if (final_word)   state_nxt = S_DONE;
                  else if (load_hs) state_nxt = S_PLAY;
                  else if (last_hs) state_nxt = S_DONE;
                  else              state_nxt = S_LOAD;
               end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // state-decoded outputs; tready is gated by enabled so an abort cycle never consumes
   always_comb begin
      s00_axis_tready = 1'b0;
      signal_state    = 1'b0;
      stopped         = 1'b0;
      case (state)
         S_LOAD:  s00_axis_tready = enabled;
         S_PLAY: begin
            signal_state    = 1'b1;
            s00_axis_tready = enabled & seg_end & ~final_word;
         end
         S_DONE:  stopped = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         signal_output <= IDLE_LEVEL;
         cnt           <= '0;
         final_word    <= 1'b0;
         underrun      <= 1'b0;
         fifo_reset    <= 1'b0;
         words_played  <= 16'd0;
      end else begin
         fifo_reset <= ~enabled & (state != S_IDLE);
         if (!enabled) begin
            signal_output <= IDLE_LEVEL;
            cnt           <= '0;
         end else begin
            case (state)
               S_ARMED: begin
                  signal_output <= IDLE_LEVEL;
                  underrun      <= 1'b0;
                  words_played  <= 16'd0;
               end
               S_LOAD, S_PLAY: begin
                  if (load_hs) begin
                     signal_output <= s00_axis_tdata[DW];
                     cnt           <= dur_eff;
                     final_word    <= final_in;
                     words_played  <= wp_inc;
                  end else if (state == S_LOAD) begin
                     signal_output <= IDLE_LEVEL;
                  end else if (seg_end) begin
                     signal_output <= IDLE_LEVEL;
                     cnt           <= '0;
                     if (!final_word && !last_hs) underrun <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               default: signal_output <= IDLE_LEVEL;
            endcase
         end
      end
   end

endmodule
